// File: rtl/bus_arbiter.sv
// Two-master arbiter (instruction fetch / data) onto one shared single-outstanding bus.
// Data normally has priority; a waiting fetch wins after STARVE_MAX consecutive data grants.
module bus_arbiter #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic        stall_req
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DONE} state_t;

  localparam logic [7:0] WAIT_LAST    = 8'(TIMEOUT - 1);
  localparam logic [2:0] STARVE_LIMIT = 3'(STARVE_MAX);

  state_t     state_reg;
  logic [2:0] starve_cnt_reg;
  logic [7:0] wait_cnt_reg;
  logic       flushed_reg;

  logic       starved;
  logic       grant_fetch;
  logic       grant_mem;
  logic       timed_out;
  logic       if_dropped;
  logic [2:0] starve_inc;

  assign starved     = (starve_cnt_reg == STARVE_LIMIT);
  assign grant_fetch = if_req & ~flush & (~mem_req | starved);
  assign grant_mem   = mem_req & ~grant_fetch;
  assign timed_out   = ~bus_ack & (wait_cnt_reg == WAIT_LAST);
  // A flush seen in any cycle of the fetch cancels its completion, not just one coinciding with the ack.
  assign if_dropped  = flushed_reg | flush;
  assign starve_inc  = (starve_cnt_reg == 3'd7) ? 3'd7 : starve_cnt_reg + 3'd1;

  assign stall_req = (if_req & ~if_ack & ~flush) | (mem_req & ~mem_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= 3'd0;
      wait_cnt_reg   <= 8'd0;
      flushed_reg    <= 1'b0;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= 32'h0;
      bus_wdata      <= 32'h0;
      bus_sel        <= 4'h0;
      bus_err        <= 1'b0;
      if_rdata       <= 32'h0;
      if_ack         <= 1'b0;
      mem_rdata      <= 32'h0;
      mem_ack        <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      bus_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_fetch) begin
            bus_req        <= 1'b1;
            bus_we         <= 1'b0;
            bus_addr       <= if_addr;
            bus_wdata      <= 32'h0;
            bus_sel        <= 4'hF;
            starve_cnt_reg <= 3'd0;
            wait_cnt_reg   <= 8'd0;
            flushed_reg    <= 1'b0;
            state_reg      <= IF_BUSY;
          end else if (grant_mem) begin
            bus_req        <= 1'b1;
            bus_we         <= mem_we;
            bus_addr       <= mem_addr;
            bus_wdata      <= mem_wdata;
            bus_sel        <= mem_sel;
            starve_cnt_reg <= if_req ? starve_inc : 3'd0;
            wait_cnt_reg   <= 8'd0;
            flushed_reg    <= 1'b0;
            state_reg      <= MEM_BUSY;
          end
        end
        IF_BUSY: begin
          if (flush) begin
            flushed_reg <= 1'b1;
          end
          if (bus_ack || timed_out) begin
            bus_req   <= 1'b0;
            state_reg <= DONE;
            if (!if_dropped) begin
              if_ack   <= 1'b1;
              bus_err  <= ~bus_ack;
              if_rdata <= bus_ack ? bus_rdata : 32'h0;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        MEM_BUSY: begin
          if (bus_ack || timed_out) begin
            bus_req   <= 1'b0;
            mem_ack   <= 1'b1;
            bus_err   <= ~bus_ack;
            state_reg <= DONE;
            // Write completions leave the last read data in place; an abort zeroes it.
            if (!bus_ack) begin
              mem_rdata <= 32'h0;
            end else if (!bus_we) begin
              mem_rdata <= bus_rdata;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255; the maximum number of cycles to wait for bus_ack before abort (range 1..255).
REQ-002 SHALL have parameter STARVE_MAX, default 4; the number of consecutive data grants after which a waiting fetch is granted next.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- if_req  in  1  instruction fetch request, held until if_ack.
- if_addr  in  32  fetch address.
- flush  in  1  cancels the pending fetch.
- if_rdata  out  32  fetch data.
- if_ack  out  1  fetch done, one-cycle pulse.
- mem_req  in  1  data request, held until mem_ack.
- mem_we  in  1  data write enable.
- mem_addr  in  32  data address.
- mem_wdata  in  32  data write data.
- mem_sel  in  4  data byte enables.
- mem_rdata  out  32  data read data.
- mem_ack  out  1  data done, one-cycle pulse.
- bus_req, bus_we  out  1  shared bus request and write enable.
- bus_addr, bus_wdata  out  32  shared bus address and write data.
- bus_sel  out  4  shared bus byte enables.
- bus_rdata  in  32  shared bus read data.
- bus_ack  in  1  shared bus completion.
- bus_err  out  1  timeout flag, valid with the ack pulse.
- stall_req  out  1  pipeline stall request.

Function
REQ-005 SHALL implement the states IDLE, IF_BUSY, MEM_BUSY and DONE.
REQ-006 In IDLE, at a clock edge, SHALL grant as follows:
- mem_req wins over if_req.
- Exception: if_req wins when starve_cnt equals STARVE_MAX.
- No request: stay in IDLE.
REQ-007 On grant, SHALL latch the winner's addr, we, wdata and sel into bus_* registers; for a fetch, we=0 and sel=4'hF.
REQ-008 SHALL assert bus_req only in IF_BUSY and MEM_BUSY, driven from registers; bus_* fields SHALL stay stable while bus_req is high.
REQ-009 In a BUSY state, bus_ack sampled high SHALL trigger these actions:
- Capture bus_rdata into the matching *_rdata register.
- Pulse the matching *_ack for exactly one cycle.
- Drop bus_req.
- Go to DONE.
REQ-010 DONE SHALL last one cycle and then return to IDLE.
- Back-to-back transactions therefore cost at least 3 cycles each (grant, ack, DONE).
- The requester has the DONE cycle to deassert or change its request.
REQ-011 starve_cnt (3 bits, saturating) SHALL update on every grant:
- Data grant with if_req high: increment.
- Fetch grant: clear.
- Data grant with if_req low: clear.
REQ-012 A wait counter SHALL clear on grant and increment each BUSY cycle without bus_ack.
REQ-013 On reaching TIMEOUT, SHALL take these actions:
- Drop bus_req.
- Pulse the matching *_ack with bus_err=1 and *_rdata=0.
- Go to DONE.
- bus_err SHALL otherwise be 0.
REQ-014 flush high during IF_BUSY SHALL let the bus transaction finish but suppress if_ack and leave if_rdata unchanged.
REQ-015 flush high in IDLE SHALL block a fetch grant in that cycle.
REQ-016 mem_rdata SHALL NOT be updated by writes; if_rdata and mem_rdata SHALL hold their values between acks.
REQ-017 stall_req SHALL be combinational: (if_req & ~if_ack & ~flush) | (mem_req & ~mem_ack).
REQ-018 bus_ack arriving in IDLE or DONE SHALL be ignored.
REQ-019 Requests that drop before their ack SHALL NOT abort a granted bus transaction.

Reset
REQ-020 While rst=0, asynchronously, SHALL set:
- State IDLE.
- All bus_* outputs, *_rdata, *_ack, bus_err, starve_cnt and the wait counter to 0.
REQ-021 Reset asserted mid-transaction SHALL drop bus_req immediately; no ack SHALL be issued for that transaction.
REQ-022 After rst rises, the first grant SHALL occur at the first following clock edge that sees a request.

Verification
REQ-023 Single fetch: if_req=1, if_addr=0x00000010, bus_ack one cycle after bus_req with bus_rdata=0x3C010001 -> if_rdata=0x3C010001, if_ack pulses once, bus_we=0, bus_sel=4'hF.
REQ-024 Simultaneous requests: if_req and mem_req (write 0xDEADBEEF to 0x100, sel=4'b0011) rise together -> data transaction first with bus_wdata=0xDEADBEEF and bus_sel=4'b0011; fetch granted after DONE.
REQ-025 Starvation: mem_req held with continuous acks and if_req held, STARVE_MAX=4 -> 4 data grants, then 1 fetch grant, starve_cnt=0.
REQ-026 Timeout: TIMEOUT=8, bus_ack never asserted -> bus_req drops after 8 BUSY cycles; mem_ack=1, bus_err=1, mem_rdata=0 for one cycle.
REQ-027 Flush: flush pulsed during IF_BUSY, bus_ack later -> no if_ack, if_rdata unchanged, state passes through DONE to IDLE.
REQ-028 Reset mid-operation: rst=0 in MEM_BUSY -> bus_req=0 without a clock edge; no mem_ack after release.
